// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field view, reciprocal ROM and FSM state type
// used by taylor_term_gen and its multiplier.
package fp32_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3F800000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam int          EXP_BIAS  = 127;

  // Field view of an FP32 word.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // Term generator sequencing.
  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    MUL_X,
    MUL_INV
  } state_t;

  // Round-to-nearest FP32 value of 1/n, n = 1..15. Entry 0 is unused and reads 1.0.
  // NOTE: a constant table synthesises to plain logic; it has no storage and needs no reset.
  localparam logic [15:0][31:0] INV_ROM = {
    32'h3D888889,  // 1/15
    32'h3D924925,  // 1/14
    32'h3D9D89D9,  // 1/13
    32'h3DAAAAAB,  // 1/12
    32'h3DBA2E8C,  // 1/11
    32'h3DCCCCCD,  // 1/10
    32'h3DE38E39,  // 1/9
    32'h3E000000,  // 1/8
    32'h3E124925,  // 1/7
    32'h3E2AAAAB,  // 1/6
    32'h3E4CCCCD,  // 1/5
    32'h3E800000,  // 1/4
    32'h3EAAAAAB,  // 1/3
    32'h3F000000,  // 1/2
    32'h3F800000,  // 1/1
    32'h3F800000   // unused
  };

endpackage

// File: rtl/fp32_mul.sv
// Single-cycle combinational FP32 multiplier.
// Zero/denormal inputs and underflowing results flush to signed zero;
// inf inputs and overflowing results saturate to signed inf and raise ovf.
// No NaN is ever produced.
// Build option: define TAYLOR_RNE_EN for round-to-nearest-even; otherwise the
// mantissa is truncated (round toward zero).
module fp32_mul
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        ovf
);

  fp32_t       fa, fb;
  logic        sign;
  logic [47:0] prod;
  logic        norm;
  logic [22:0] man;
  logic [9:0]  exp_sum;  // biased sum ea + eb (+ normalise/round carries), bias not yet removed
`ifdef TAYLOR_RNE_EN
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic        carry;
`else
  logic        unused_low;
`endif

  // Multiply significands, normalise by at most one bit, round, then apply range rules.
  always_comb begin
    // NOTE: every output of this block is assigned before any branch, so no latch can be inferred.
    y       = '0;
    ovf     = 1'b0;
    fa      = a;
    fb      = b;
    sign    = fa.sign ^ fb.sign;
    prod    = 48'({1'b1, fa.man}) * 48'({1'b1, fb.man});
    norm    = prod[47];
    exp_sum = {2'b00, fa.exp} + {2'b00, fb.exp} + {9'd0, norm};
    man     = norm ? prod[46:24] : prod[45:23];
`ifdef TAYLOR_RNE_EN
    guard_bit  = norm ? prod[23] : prod[22];
    sticky_bit = norm ? |prod[22:0] : |prod[21:0];
    round_up   = guard_bit & (sticky_bit | man[0]);
    {carry, man} = {1'b0, man} + {23'd0, round_up};
    // A carry out means the significand rolled over to 2.0: man is already 0, bump the exponent.
    exp_sum = exp_sum + {9'd0, carry};
`else
    unused_low = ^prod[22:0];
`endif

    if (fa.exp == 8'hFF || fb.exp == 8'hFF) begin
      y   = FP32_PINF | {sign, 31'd0};
      ovf = 1'b1;
    end else if (fa.exp == 8'd0 || fb.exp == 8'd0) begin
      y = {sign, 31'd0};
    end else if (exp_sum <= 10'(EXP_BIAS)) begin
      y = {sign, 31'd0};
    end else if (exp_sum >= 10'(EXP_BIAS + 255)) begin
      y   = FP32_PINF | {sign, 31'd0};
      ovf = 1'b1;
    end else begin
      y = {sign, 8'(exp_sum - 10'(EXP_BIAS)), man};
    end
  end

endmodule

// File: rtl/taylor_term_gen.sv
// Sequential Taylor-term feeder for exp(x): emits t0..t(N_TERMS-1), tn = x^n/n!,
// over a valid/ready stream using t(n) = (t(n-1) * x) * (1/n) on one shared multiplier.
// Build option: TAYLOR_RNE_EN (see fp32_mul) selects round-to-nearest-even multiplies.
module taylor_term_gen
  import fp32_pkg::*;
#(
  parameter int N_TERMS = 7,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      x,
  output logic             busy,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [31:0]      term,
  output logic [IDX_W-1:0] term_idx,
  output logic             term_last,
  output logic             ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

  state_t           state, state_nxt;
  logic [31:0]      x_q;
  logic [31:0]      acc;
  logic [IDX_W-1:0] n;
  logic [3:0]       rom_idx;
  logic [31:0]      mul_b;
  logic [31:0]      mul_y;
  logic             mul_ovf;

  assign rom_idx = 4'(n);

  fp32_mul u_mul (
    .a   (acc),
    .b   (mul_b),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  // Next state, stream outputs and multiplier operand select.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    term_valid = 1'b0;
    term       = '0;
    term_idx   = '0;
    term_last  = 1'b0;
    mul_b      = x_q;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = EMIT;
      end
      EMIT: begin
        term_valid = 1'b1;
        term       = acc;
        term_idx   = n;
        term_last  = (n == LAST_IDX);
        if (term_ready) state_nxt = (n == LAST_IDX) ? IDLE : MUL_X;
      end
      MUL_X: begin
        mul_b     = x_q;
        state_nxt = MUL_INV;
      end
      MUL_INV: begin
        mul_b     = INV_ROM[rom_idx];
        state_nxt = EMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, running term, index and sticky overflow; reset aborts any sequence.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      x_q   <= '0;
      acc   <= '0;
      n     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_q <= x;
            acc <= FP32_ONE;
            n   <= '0;
            ovf <= 1'b0;
          end
        end
        EMIT: begin
          if (term_ready && n != LAST_IDX) n <= n + 1'b1;
        end
        MUL_X, MUL_INV: begin
          acc <= mul_y;
          ovf <= ovf | mul_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule
